shifter_pipe: RTL and testbench



---
 rtl/shifter_pipe.sv | 131 +++++++++++++
 tb/tb_shifter_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: one register stage per shift layer, SLL/SRL/SRA/ROR,
// valid/ready handshake with a global stall.
module shifter_pipe #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
        return r;
    endfunction

    // One right-shift layer; fill depends on mode (SLL runs bit-reversed as SRL).
    function automatic logic [WIDTH-1:0] shr_step(input logic [WIDTH-1:0] x,
                                                  input logic [1:0] op,
                                                  input logic sgn,
                                                  input int unsigned amt);
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] r;
        ones = '1;
        case (op)
            OP_ROR:  r = (x >> amt) | (x << (WIDTH - amt));
            OP_SRA:  r = (x >> amt) | (sgn ? ~(ones >> amt) : '0);
            default: r = x >> amt;
        endcase
        return r;
    endfunction

    logic             v_q   [SHW];
    logic [WIDTH-1:0] d_q   [SHW];
    logic [SHW-1:0]   sh_q  [SHW-1];
    logic [1:0]       op_q  [SHW-1];
    logic             sgn_q [SHW-1];
    logic             zero_q;

    logic             v_d   [SHW];
    logic [WIDTH-1:0] d_d   [SHW];
    logic [SHW-1:0]   sh_d  [SHW];
    logic [1:0]       op_d  [SHW];
    logic             sgn_d [SHW];

    logic advance;

    assign advance   = !v_q[SHW-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[SHW-1];
    assign out_data  = d_q[SHW-1];
    assign out_zero  = zero_q;

    for (genvar s = 0; s < SHW; s++) begin : g_stage
        logic             src_v;
        logic [WIDTH-1:0] src_d;
        logic [SHW-1:0]   src_sh;
        logic [1:0]       src_op;
        logic             src_sgn;
        logic [WIDTH-1:0] shifted;

        if (s == 0) begin : g_entry
            assign src_v   = in_valid;
            assign src_d   = (in_op == OP_SLL) ? bit_rev(in_data) : in_data;
            assign src_sh  = in_shamt;
            assign src_op  = in_op;
            assign src_sgn = in_data[WIDTH-1];
        end else begin : g_chain
            assign src_v   = v_q[s-1];
            assign src_d   = d_q[s-1];
            assign src_sh  = sh_q[s-1];
            assign src_op  = op_q[s-1];
            assign src_sgn = sgn_q[s-1];
        end

        assign shifted = src_sh[s] ? shr_step(src_d, src_op, src_sgn, 32'(1) << s) : src_d;

        // Final layer undoes the entry reversal for left shifts.
        if (s == SHW - 1) begin : g_last
            assign d_d[s] = (src_op == OP_SLL) ? bit_rev(shifted) : shifted;
        end else begin : g_mid
            assign d_d[s] = shifted;
        end

        assign v_d[s]   = src_v;
        assign sh_d[s]  = src_sh;
        assign op_d[s]  = src_op;
        assign sgn_d[s] = src_sgn;
    end

    // Every stage advances together; on stall all stages (bubbles included) hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SHW; s++) begin
                v_q[s] <= 1'b0;
                d_q[s] <= '0;
            end
            for (int s = 0; s < SHW - 1; s++) begin
                sh_q[s]  <= '0;
                op_q[s]  <= '0;
                sgn_q[s] <= 1'b0;
            end
            zero_q <= 1'b0;
        end else if (advance) begin
            for (int s = 0; s < SHW; s++) begin
                v_q[s] <= v_d[s];
                d_q[s] <= d_d[s];
            end
            for (int s = 0; s < SHW - 1; s++) begin
                sh_q[s]  <= sh_d[s];
                op_q[s]  <= op_d[s];
                sgn_q[s] <= sgn_d[s];
            end
            zero_q <= (d_d[SHW-1] == '0);
        end
    end

endmodule

// File: tb/tb_shifter_pipe.sv
// Randomized, self-checking bench for shifter_pipe against a queue-based reference model.
module tb_shifter_pipe;

    localparam int unsigned W  = 32;
    localparam int unsigned SW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [SW-1:0] in_shamt = '0;
    logic [1:0]    in_op = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          out_zero;

    shifter_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    int emitted = 0;
    logic [W-1:0] expq[$];
    logic [W-1:0] cur_exp = '0;
    logic rand_bp = 1'b0;
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic prev_zero = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input int n,
                                               input logic [1:0] op);
        case (op)
            2'b00:   return a << n;
            2'b01:   return a >> n;
            2'b10:   return W'($signed(a) >>> n);
            default: return (n == 0) ? a : ((a >> n) | (a << (W - n)));
        endcase
    endfunction

    // Compare process: checks in_ready, stall stability and in-order results every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'(1));
                chk("stall_data", 64'(out_data), 64'(prev_data));
                chk("stall_zero", 64'(out_zero), 64'(prev_zero));
            end
            if (out_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h with no beat outstanding", out_data);
                end else begin
                    chk("out_data", 64'(out_data), 64'(expq[0]));
                    chk("out_zero", 64'(out_zero), 64'(expq[0] == '0));
                    if (out_ready) begin
                        void'(expq.pop_front());
                        emitted++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(cur_exp);
                accepted++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_zero  = out_zero;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [W-1:0] a, input int n, input logic [1:0] op,
                        input logic [W-1:0] exp);
        logic ok;
        int guard;
        guard = 0;
        in_data = a; in_shamt = SW'(n); in_op = op; cur_exp = exp; in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            tick();
            guard++;
        end while (!ok && guard < 200);
        if (!ok) chk("send_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [W-1:0] a;
        int n;
        logic [1:0] op;
        a = $urandom; n = $urandom_range(0, W - 1); op = 2'($urandom_range(0, 3));
        send(a, n, op, ref_shift(a, n, op));
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while ((expq.size() != 0 || out_valid) && k < limit) begin
            tick();
            k++;
        end
        chk("drain_timeout", 64'(expq.size()), 64'(0));
    endtask

    task automatic timed(input logic [W-1:0] a, input int n, input logic [1:0] op,
                         input logic [W-1:0] exp);
        int lat;
        lat = 0;
        send(a, n, op, exp);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(SW - 1));
        drain(50);
    endtask

    initial begin
        int a0, e0, t0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_zero", 64'(out_zero), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Hand-computed literals pin the model, then the same beats run through the DUT.
        chk("model_sll31", 64'(ref_shift(32'h1, 31, 2'b00)), 64'h8000_0000);
        chk("model_sra", 64'(ref_shift(32'h8000_00F0, 4, 2'b10)), 64'hF800_000F);
        chk("model_srl", 64'(ref_shift(32'h8000_00F0, 4, 2'b01)), 64'h0800_000F);
        chk("model_ror", 64'(ref_shift(32'h0000_00F1, 4, 2'b11)), 64'h1000_000F);
        timed(32'h1, 31, 2'b00, 32'h8000_0000);
        send(32'h8000_00F0, 4, 2'b10, 32'hF800_000F);
        send(32'h8000_00F0, 4, 2'b01, 32'h0800_000F);
        send(32'h0000_00F1, 4, 2'b11, 32'h1000_000F);
        send(32'h1, 0, 2'b00, 32'h1);
        send(32'h1, 1, 2'b01, 32'h0);
        send(32'hDEAD_BEEF, 0, 2'b10, 32'hDEAD_BEEF);
        send(32'hDEAD_BEEF, 0, 2'b11, 32'hDEAD_BEEF);
        drain(50);

        // Back-to-back stream: one acceptance per cycle with out_ready high.
        t0 = int'($time);
        for (int i = 0; i < 32; i++) begin
            if (i == 0) send(32'h1234_5678, 0, 2'($urandom_range(0, 3)), 32'h1234_5678);
            else send_rand();
        end
        chk("stream_cycles", 64'((int'($time) - t0) / 10), 64'(32));
        drain(50);

        // Fill the pipe with out_ready low, hold the stall, then release.
        out_ready = 1'b0;
        a0 = accepted; e0 = emitted;
        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] a;
            int n;
            logic [1:0] op;
            a = $urandom; n = $urandom_range(0, W - 1); op = 2'($urandom_range(0, 3));
            in_data = a; in_shamt = SW'(n); in_op = op; cur_exp = ref_shift(a, n, op);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("stall_accepted", 64'(accepted - a0), 64'(SW));
        out_ready = 1'b1;
        drain(50);
        chk("stall_emitted", 64'(emitted - e0), 64'(SW));

        // Random traffic with random backpressure and input gaps.
        rand_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send_rand();
        end
        drain(2000);
        rand_bp = 1'b0;
        out_ready = 1'b1;

        // Reset with three beats in flight.
        send_rand();
        send_rand();
        send_rand();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_out_data", 64'(out_data), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        expq.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) tick();
        chk("post_rst_quiet", 64'(out_valid), 64'(0));
        timed(32'hF000_0000, 28, 2'b10, 32'hFFFF_FFFF);
        timed(32'h0000_0003, 1, 2'b11, 32'h8000_0001);

        chk("final_queue_empty", 64'(expq.size()), 64'(0));
        chk("final_balance", 64'(accepted - emitted), 64'(3));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
